// File: rtl/riscv_dcache_pkg.sv
// Shared types for the set-associative data cache:
// FSM state encoding, access-size codes and a width helper.
package riscv_dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  // Keeps vector widths legal when a field would be 0 bits.
  function automatic int min1(int n);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/riscv_dcache_assoc_if.sv
// Cache <-> memory line bus: read/write request held until mem_ready.
// master = cache side, slave = memory side.
interface riscv_dcache_assoc_if #(
  parameter int DW = 128,
  parameter int SA = 23
);
  logic          i_riscv_dcache_mem_ready;
  logic [DW-1:0] i_riscv_dcache_mem_data_out;
  logic [DW-1:0] o_riscv_dcache_mem_data_in;
  logic [SA-1:0] o_riscv_dcache_mem_addr;
  logic          o_riscv_dcache_fsm_mem_wren;
  logic          o_riscv_dcache_fsm_mem_rden;

  modport master (
    input  i_riscv_dcache_mem_ready,
    input  i_riscv_dcache_mem_data_out,
    output o_riscv_dcache_mem_data_in,
    output o_riscv_dcache_mem_addr,
    output o_riscv_dcache_fsm_mem_wren,
    output o_riscv_dcache_fsm_mem_rden
  );

  modport slave (
    output i_riscv_dcache_mem_ready,
    output i_riscv_dcache_mem_data_out,
    input  o_riscv_dcache_mem_data_in,
    input  o_riscv_dcache_mem_addr,
    input  o_riscv_dcache_fsm_mem_wren,
    input  o_riscv_dcache_fsm_mem_rden
  );
endinterface

// File: rtl/riscv_dcache_plru.sv
// Tree-PLRU for one set: state bits in heap order (node n -> bit n-1),
// each bit points toward the less recently used subtree.
module riscv_dcache_plru
  import riscv_dcache_pkg::*;
#(
  parameter  int WAYS = 2,
  localparam int WIDX = min1($clog2(WAYS)),
  localparam int PW   = min1(WAYS - 1)
) (
  input  logic [PW-1:0]   state,
  input  logic [WIDX-1:0] touch,
  output logic [PW-1:0]   next_state,
  output logic [WIDX-1:0] victim
);

  localparam int LV = $clog2(WAYS);

  always_comb begin
    int   node;
    logic b;
    next_state = state;
    victim     = '0;
    node       = 1;
    b          = 1'b0;
    if (WAYS > 1) begin
      for (int l = 0; l < LV; l++) begin
        b    = 1'(state >> (node - 1));
        node = 2 * node + int'(b);
      end
      victim = WIDX'(node - WAYS);
      node = 1;
      for (int l = 0; l < LV; l++) begin
        b = 1'(touch >> (LV - 1 - l));
        // Point away from the way just used.
        if (b)
          next_state = next_state & ~(PW'(1) << (node - 1));
        else
          next_state = next_state | (PW'(1) << (node - 1));
        node = 2 * node + int'(b);
      end
    end
  end

endmodule

// File: rtl/riscv_dcache_assoc.sv
// Write-back, write-allocate N-way data cache with tree-PLRU.
// Ports: CPU load/store side as scalars, memory line bus via mem_if.
module riscv_dcache_assoc
  import riscv_dcache_pkg::*;
#(
  parameter  int DATA_WIDTH = 128,
  parameter  int CACHE_SIZE = 4096,
  parameter  int MEM_SIZE   = 2**27,
  parameter  int WAYS       = 2,
  localparam int ADDR     = $clog2(MEM_SIZE),
  localparam int BYTE_OFF = $clog2(DATA_WIDTH/8),
  localparam int SETS     = CACHE_SIZE/(DATA_WIDTH/8)/WAYS,
  localparam int INDEX    = $clog2(SETS),
  localparam int TAG      = ADDR - INDEX - BYTE_OFF,
  localparam int S_ADDR   = ADDR - BYTE_OFF,
  localparam int WIDX     = min1($clog2(WAYS)),
  localparam int PW       = min1(WAYS - 1)
) (
  input  logic            i_riscv_dcache_clk,
  input  logic            i_riscv_dcache_rst_n,
  input  logic            i_riscv_dcache_globstall,
  input  logic            i_riscv_dcache_cpu_wren,
  input  logic            i_riscv_dcache_cpu_rden,
  input  logic [1:0]      i_riscv_dcache_store_src,
  input  logic [ADDR-1:0] i_riscv_dcache_phys_addr,
  input  logic [63:0]     i_riscv_dcache_cpu_data_in,
  output logic [63:0]     o_riscv_dcache_cpu_data_out,
  output logic            o_riscv_dcache_cpu_stall,
  riscv_dcache_assoc_if.master mem_if
);

  logic [TAG-1:0]        tag_arr  [WAYS][SETS];
  logic [DATA_WIDTH-1:0] data_arr [WAYS][SETS];
  logic [WAYS-1:0]       valid_q  [SETS];
  logic [WAYS-1:0]       dirty_q  [SETS];
  logic [PW-1:0]         plru_q   [SETS];

  state_e          state_q;
  logic [WIDX-1:0] victim_q;
  logic [TAG-1:0]  req_tag;
  logic [INDEX-1:0] req_idx;

  logic [TAG-1:0]   a_tag;
  logic [INDEX-1:0] a_idx;
  logic [BYTE_OFF-1:0] a_off;
  assign a_tag = i_riscv_dcache_phys_addr[ADDR-1 -: TAG];
  assign a_idx = i_riscv_dcache_phys_addr[BYTE_OFF +: INDEX];
  assign a_off = i_riscv_dcache_phys_addr[BYTE_OFF-1:0];

  logic active, is_store, hit, miss, mem_ready, fill;
  logic [WIDX-1:0] hit_way, victim, plru_vic;
  logic [PW-1:0]   plru_nxt;
  logic [DATA_WIDTH-1:0] hit_line, wline;

  assign mem_ready = mem_if.i_riscv_dcache_mem_ready;
  assign is_store  = i_riscv_dcache_cpu_wren;
  assign active = (state_q == IDLE) && !i_riscv_dcache_globstall &&
                  (i_riscv_dcache_cpu_wren || i_riscv_dcache_cpu_rden);
  assign miss = active && !hit;
  assign fill = (state_q == ALLOCATE) && mem_ready;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[a_idx][w] && tag_arr[w][a_idx] == a_tag) begin
        hit     = 1'b1;
        hit_way = WIDX'(w);
      end
    end
  end

  assign hit_line = data_arr[hit_way][a_idx];
  assign o_riscv_dcache_cpu_data_out =
    64'(hit_line >> {a_off[BYTE_OFF-1:3], 6'b0});

  assign o_riscv_dcache_cpu_stall = i_riscv_dcache_rst_n &
    ((state_q != IDLE) | miss);

  riscv_dcache_plru #(.WAYS(WAYS)) u_plru (
    .state      (plru_q[a_idx]),
    .touch      (hit_way),
    .next_state (plru_nxt),
    .victim     (plru_vic)
  );

  // Lowest invalid way wins; descending scan lets it overwrite.
  always_comb begin
    victim = plru_vic;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[a_idx][w]) victim = WIDX'(w);
    end
  end

  // Store merge: offset bits below the access size are dropped.
  always_comb begin
    int nb;
    int base;
    case (i_riscv_dcache_store_src)
      SZ_BYTE: nb = 1;
      SZ_HALF: nb = 2;
      SZ_WORD: nb = 4;
      default: nb = 8;
    endcase
    base  = int'(a_off) & ~(nb - 1);
    wline = hit_line;
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      if (b >= base && b < base + nb)
        wline[8*b +: 8] =
          8'(i_riscv_dcache_cpu_data_in >> (8 * (b - base)));
    end
  end

  always_ff @(posedge i_riscv_dcache_clk) begin
    if (active && hit && is_store)
      data_arr[hit_way][a_idx] <= wline;
    if (fill) begin
      data_arr[victim_q][req_idx] <= mem_if.i_riscv_dcache_mem_data_out;
      tag_arr[victim_q][req_idx]  <= req_tag;
    end
  end

  always_ff @(posedge i_riscv_dcache_clk or negedge i_riscv_dcache_rst_n) begin
    if (!i_riscv_dcache_rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (active && hit) begin
        plru_q[a_idx] <= plru_nxt;
        if (is_store) dirty_q[a_idx][hit_way] <= 1'b1;
      end
      if (fill) begin
        valid_q[req_idx][victim_q] <= 1'b1;
        dirty_q[req_idx][victim_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_riscv_dcache_clk or negedge i_riscv_dcache_rst_n) begin
    if (!i_riscv_dcache_rst_n) begin
      state_q  <= IDLE;
      victim_q <= '0;
      req_tag  <= '0;
      req_idx  <= '0;
      mem_if.o_riscv_dcache_fsm_mem_wren <= 1'b0;
      mem_if.o_riscv_dcache_fsm_mem_rden <= 1'b0;
      mem_if.o_riscv_dcache_mem_addr     <= '0;
      mem_if.o_riscv_dcache_mem_data_in  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss) begin
            victim_q <= victim;
            req_tag  <= a_tag;
            req_idx  <= a_idx;
            if (dirty_q[a_idx][victim]) begin
              state_q <= WRITEBACK;
              mem_if.o_riscv_dcache_fsm_mem_wren <= 1'b1;
              mem_if.o_riscv_dcache_mem_addr <=
                {tag_arr[victim][a_idx], a_idx};
              mem_if.o_riscv_dcache_mem_data_in <=
                data_arr[victim][a_idx];
            end else begin
              state_q <= ALLOCATE;
              mem_if.o_riscv_dcache_fsm_mem_rden <= 1'b1;
              mem_if.o_riscv_dcache_mem_addr <= {a_tag, a_idx};
            end
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            state_q <= ALLOCATE;
            mem_if.o_riscv_dcache_fsm_mem_wren <= 1'b0;
            mem_if.o_riscv_dcache_fsm_mem_rden <= 1'b1;
            mem_if.o_riscv_dcache_mem_addr <= {req_tag, req_idx};
          end
        end
        ALLOCATE: begin
          if (mem_ready) begin
            state_q <= IDLE;
            mem_if.o_riscv_dcache_fsm_mem_rden <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_dcache_assoc.sv
// Scoreboard bench for riscv_dcache_assoc: golden line model,
// memory responder with latency, load/writeback expectation queues.
module tb_riscv_dcache_assoc;

  typedef struct packed {
    logic [22:0]  a;
    logic [127:0] d;
  } wb_t;

  localparam int MEM_LAT = 2;

  logic        clk = 0;
  logic        rst_n;
  logic        globstall, wren, rden;
  logic [1:0]  src;
  logic [26:0] addr;
  logic [63:0] din;
  logic [63:0] dout;
  logic        stall;
  logic        hold_mem;
  int          lat_cnt;
  int          checks = 0;
  int          failures = 0;

  logic [127:0] gold [int];
  logic [127:0] phys [int];
  logic [63:0]  exp_q [$];
  wb_t          wb_q [$];

  riscv_dcache_assoc_if #(.DW(128), .SA(23)) mif ();

  logic        wren_m, rden_m;
  logic [22:0] maddr;
  assign wren_m = mif.o_riscv_dcache_fsm_mem_wren;
  assign rden_m = mif.o_riscv_dcache_fsm_mem_rden;
  assign maddr  = mif.o_riscv_dcache_mem_addr;

  riscv_dcache_assoc dut (
    .i_riscv_dcache_clk          (clk),
    .i_riscv_dcache_rst_n        (rst_n),
    .i_riscv_dcache_globstall    (globstall),
    .i_riscv_dcache_cpu_wren     (wren),
    .i_riscv_dcache_cpu_rden     (rden),
    .i_riscv_dcache_store_src    (src),
    .i_riscv_dcache_phys_addr    (addr),
    .i_riscv_dcache_cpu_data_in  (din),
    .o_riscv_dcache_cpu_data_out (dout),
    .o_riscv_dcache_cpu_stall    (stall),
    .mem_if                      (mif.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] init_line(int la);
    return {32'hC0DE0000 | la, 32'(la * 3),
            32'hF00D0000 ^ la, 32'(la)};
  endfunction

  function automatic logic [127:0] gline(int la);
    return gold.exists(la) ? gold[la] : init_line(la);
  endfunction

  function automatic logic [127:0] pline(int la);
    return phys.exists(la) ? phys[la] : init_line(la);
  endfunction

  function automatic logic [63:0] gdw(logic [26:0] a);
    logic [127:0] l;
    l = gline(int'(a >> 4));
    return a[3] ? l[127:64] : l[63:0];
  endfunction

  function automatic void gst(logic [26:0] a, logic [1:0] sz,
                              logic [63:0] d);
    int la;
    int nb;
    int base;
    logic [127:0] l;
    la   = int'(a >> 4);
    l    = gline(la);
    nb   = 1 << sz;
    base = int'(a[3:0]) & ~(nb - 1);
    for (int i = 0; i < nb; i++)
      l[8*(base+i) +: 8] = d[8*i +: 8];
    gold[la] = l;
  endfunction

  // Memory slave: answers a held request after MEM_LAT idle cycles.
  initial begin
    wb_t e;
    lat_cnt = 0;
    mif.i_riscv_dcache_mem_ready = 1'b0;
    mif.i_riscv_dcache_mem_data_out = '0;
    forever begin
      @(negedge clk);
      mif.i_riscv_dcache_mem_ready = 1'b0;
      if (!rst_n) begin
        lat_cnt = 0;
      end else if (!hold_mem && (wren_m || rden_m)) begin
        if (lat_cnt < MEM_LAT) begin
          lat_cnt++;
        end else begin
          lat_cnt = 0;
          chk("mem_mutex", 128'(wren_m & rden_m), 128'(0));
          if (wren_m) begin
            chk("wb_expected", 128'(wb_q.size() > 0), 128'(1));
            if (wb_q.size() > 0) begin
              e = wb_q.pop_front();
              chk("wb_addr", 128'(maddr), 128'(e.a));
              chk("wb_data", mif.o_riscv_dcache_mem_data_in, e.d);
            end
            phys[int'(maddr)] = mif.o_riscv_dcache_mem_data_in;
          end else begin
            mif.i_riscv_dcache_mem_data_out = pline(int'(maddr));
          end
          mif.i_riscv_dcache_mem_ready = 1'b1;
        end
      end
    end
  end

  task automatic wait_done(output int cyc);
    cyc = 0;
    #1;
    while (stall === 1'b1 && cyc < 300) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("timeout", 128'(stall), 128'(0));
  endtask

  task automatic access(input bit wr, input logic [26:0] a,
                        input logic [1:0] sz, input logic [63:0] d,
                        input string tag, output int cyc);
    @(negedge clk);
    addr = a; src = sz; din = d;
    wren = wr; rden = !wr;
    if (wr) gst(a, sz, d);
    else exp_q.push_back(gdw(a));
    wait_done(cyc);
    if (!wr) chk(tag, 128'(dout), 128'(exp_q.pop_front()));
    @(posedge clk);
    #1;
    wren = 0; rden = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cyc;
    int changed;
    rst_n = 0; globstall = 0; wren = 0; rden = 0;
    src = 2'b11; addr = '0; din = '0; hold_mem = 0;
    phys[16] = 128'h0123456789ABCDEF_FEDCBA9876541122;
    gold = phys;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 128'(stall), 128'(0));
    chk("rst_wren", 128'(wren_m), 128'(0));
    chk("rst_rden", 128'(rden_m), 128'(0));
    @(negedge clk);
    rst_n = 1;

    // Cold miss, then memory held off for 50 cycles.
    hold_mem = 1;
    @(negedge clk);
    addr = 27'h100; rden = 1; src = 2'b11;
    exp_q.push_back(gdw(27'h100));
    #1;
    chk("miss_stall", 128'(stall), 128'(1));
    @(posedge clk);
    #1;
    chk("miss_rden", 128'(rden_m), 128'(1));
    chk("miss_wren", 128'(wren_m), 128'(0));
    chk("miss_addr", 128'(maddr), 128'(23'h10));
    changed = 0;
    repeat (50) begin
      @(negedge clk);
      #1;
      if (stall !== 1'b1 || rden_m !== 1'b1 ||
          wren_m !== 1'b0 || maddr !== 23'h10)
        changed++;
    end
    chk("hold50", 128'(changed), 128'(0));
    hold_mem = 0;
    wait_done(cyc);
    chk("refill_data", 128'(dout), 128'(exp_q.pop_front()));
    @(posedge clk);
    #1;
    rden = 0;

    // Store sizes on a resident line.
    access(1, 27'h105, 2'b00, 64'hAB, "st_b", cyc);
    chk("st_nostall", 128'(cyc), 128'(0));
    access(0, 27'h100, 2'b11, 0, "ld_byte5", cyc);
    chk("ld_nostall", 128'(cyc), 128'(0));
    access(1, 27'h10B, 2'b01, 64'hBEEF, "st_h", cyc);
    access(1, 27'h10C, 2'b10, 64'hCAFEF00D, "st_w", cyc);
    access(0, 27'h108, 2'b11, 0, "ld_hw", cyc);
    access(1, 27'h100, 2'b11, 64'h1122334455667788, "st_d", cyc);
    access(1, 27'h107, 2'b00, 64'h5A, "st_b7", cyc);
    access(0, 27'h100, 2'b11, 0, "ld_dw", cyc);

    // Set 0: two fills, dirty way 0, touch way 1, third tag.
    access(0, 27'h800, 2'b11, 0, "fill_a", cyc);
    access(0, 27'h1000, 2'b11, 0, "fill_b", cyc);
    access(1, 27'h808, 2'b11, 64'hDEADBEEF01234567, "dirty_a", cyc);
    access(0, 27'h1000, 2'b11, 0, "touch_b", cyc);
    chk("touch_b_hit", 128'(cyc), 128'(0));
    wb_q.push_back('{a: 23'h80, d: gline(32'h80)});
    access(0, 27'h1800, 2'b11, 0, "ld_c", cyc);
    chk("ld_c_miss", 128'(cyc > 0), 128'(1));
    chk("wb_drained", 128'(wb_q.size()), 128'(0));
    access(0, 27'h808, 2'b11, 0, "reload_a", cyc);
    chk("reload_a_miss", 128'(cyc > 0), 128'(1));
    chk("no_extra_wb", 128'(wb_q.size()), 128'(0));

    // globstall toggling during ALLOCATE.
    hold_mem = 1;
    @(negedge clk);
    addr = 27'h200; rden = 1;
    exp_q.push_back(gdw(27'h200));
    @(posedge clk);
    #1;
    chk("gs_rden", 128'(rden_m), 128'(1));
    changed = 0;
    repeat (10) begin
      @(negedge clk);
      globstall = ~globstall;
      #1;
      if (stall !== 1'b1 || rden_m !== 1'b1 || maddr !== 23'h20)
        changed++;
    end
    chk("gs_hold", 128'(changed), 128'(0));
    globstall = 0;
    hold_mem = 0;
    wait_done(cyc);
    chk("gs_data", 128'(dout), 128'(exp_q.pop_front()));
    @(posedge clk);
    #1;
    rden = 0;

    // globstall in IDLE blocks a would-be miss.
    @(negedge clk);
    globstall = 1; rden = 1; addr = 27'h300;
    #1;
    chk("gs_idle_stall", 128'(stall), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("gs_idle_rden", 128'(rden_m), 128'(0));
    chk("gs_idle_wren", 128'(wren_m), 128'(0));
    rden = 0; globstall = 0;

    // Reset while a writeback is outstanding.
    access(0, 27'h400, 2'b11, 0, "fill_e", cyc);
    access(1, 27'h400, 2'b11, 64'h5555AAAA5555AAAA, "dirty_e", cyc);
    access(0, 27'hC00, 2'b11, 0, "fill_f", cyc);
    hold_mem = 1;
    @(negedge clk);
    addr = 27'h1400; rden = 1;
    @(posedge clk);
    #1;
    chk("wb_start_wren", 128'(wren_m), 128'(1));
    chk("wb_start_addr", 128'(maddr), 128'(23'h40));
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_wren_drop", 128'(wren_m), 128'(0));
    chk("rst_stall_drop", 128'(stall), 128'(0));
    rden = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    hold_mem = 0;
    gold = phys;
    access(0, 27'h1400, 2'b11, 0, "post_rst_g", cyc);
    chk("post_rst_miss", 128'(cyc > 0), 128'(1));
    access(0, 27'h400, 2'b11, 0, "post_rst_e", cyc);
    chk("sb_empty", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
